clock_bcd_scan_ctrl: RTL and testbench

Sequences one shared 6-bit binary-to-BCD converter across the three watch time fields (hours, minutes, seconds). It snapshots the fields on an update request and converts them one at a time through the converter. It then commits all six BCD digits atomically to a display register and time-multiplexes them onto a single 7-segment digit bus with a one-hot digit select. It sits between the timekeeping counters and the segment decoder.

---
 rtl/clock_bcd_scan_ctrl.sv | 177 +++++++++++++++++
 tb/tb_clock_bcd_scan_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/clock_bcd_scan_ctrl.sv
// clock_bcd_scan_ctrl: converts the h/m/s fields one at a time through a shared
// 6-bit to BCD converter, commits all six digits together, and scans them out.
// Ports: clk, rst (async, active-high); hours/minutes/seconds, update in;
// conv_bin out / conv_bcd in (external converter); busy, done status;
// digit_bcd, digit_sel scan outputs.
// Optional: define BCD_SCAN_LZ_BLANK_EN to blank a zero hours-tens digit.
module clock_bcd_scan_ctrl #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       update,
  output logic [5:0] conv_bin,
  input  logic [7:0] conv_bcd,
  output logic       busy,
  output logic       done,
  output logic [3:0] digit_bcd,
  output logic [5:0] digit_sel
);

  localparam int CW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {
    IDLE, DRIVE, CAPTURE, COMMIT
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [2:0][5:0] snap_q, snap_d;
  logic [2:0][5:0] pend_q, pend_d;
  logic            pflag_q, pflag_d;
  logic [2:0][7:0] shad_q, shad_d;
  logic [2:0][7:0] disp_q, disp_d;
  logic            done_q, done_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      scan_q, scan_d;
  logic [2:0][5:0] fields;
  logic [3:0]      nib;

  // Index 0 is seconds, so field order matches idx and display layout.
  assign fields = {hours, minutes, seconds};
  assign busy   = (state_q != IDLE);
  assign done   = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      pend_q  <= '0;
      pflag_q <= 1'b0;
      shad_q  <= '0;
      disp_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      scan_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      shad_q  <= shad_d;
      disp_q  <= disp_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      scan_q  <= scan_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    pend_d  = pend_q;
    pflag_d = pflag_q;
    shad_d  = shad_q;
    disp_d  = disp_q;
    done_d  = 1'b0;

    if (update && busy) begin
      pend_d  = fields;
      pflag_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (update) begin
          snap_d  = fields;
          idx_d   = 2'd0;
          state_d = DRIVE;
        end else if (pflag_q) begin
          snap_d  = pend_q;
          pflag_d = 1'b0;
          idx_d   = 2'd0;
          state_d = DRIVE;
        end
      end
      DRIVE: state_d = CAPTURE;
      CAPTURE: begin
        unique case (idx_q)
          2'd1:    shad_d[1] = conv_bcd;
          2'd2:    shad_d[2] = conv_bcd;
          default: shad_d[0] = conv_bcd;
        endcase
        if (idx_q < 2'd2) begin
          idx_d   = idx_q + 2'd1;
          state_d = DRIVE;
        end else begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        disp_d = shad_q;
        done_d = 1'b1;
        idx_d  = 2'd0;
        // An update landing on this edge is newer than the pending copy.
        if (update) begin
          snap_d  = fields;
          pflag_d = 1'b0;
          state_d = DRIVE;
        end else if (pflag_q) begin
          snap_d  = pend_q;
          pflag_d = 1'b0;
          state_d = DRIVE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand is held across DRIVE and CAPTURE of a field.
  always_comb begin
    conv_bin = snap_q[0];
    if (state_q != IDLE) begin
      unique case (idx_q)
        2'd1:    conv_bin = snap_q[1];
        2'd2:    conv_bin = snap_q[2];
        default: conv_bin = snap_q[0];
      endcase
    end
  end

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    scan_d = scan_q;
    if (cnt_q == CW'(SCAN_DIV - 1)) begin
      cnt_d  = '0;
      scan_d = (scan_q == 3'd5) ? 3'd0 : scan_q + 3'd1;
    end
  end

  always_comb begin
    unique case (scan_q)
      3'd1:    nib = disp_q[0][7:4];
      3'd2:    nib = disp_q[1][3:0];
      3'd3:    nib = disp_q[1][7:4];
      3'd4:    nib = disp_q[2][3:0];
      3'd5:    nib = disp_q[2][7:4];
      default: nib = disp_q[0][3:0];
    endcase
  end

  assign digit_sel = 6'd1 << scan_q;

`ifdef BCD_SCAN_LZ_BLANK_EN
  assign digit_bcd = (scan_q == 3'd5 && nib == 4'd0) ? 4'hF : nib;
`else
  assign digit_bcd = nib;
`endif

endmodule

// File: tb/tb_clock_bcd_scan_ctrl.sv
// tb_clock_bcd_scan_ctrl: directed bench for clock_bcd_scan_ctrl with a
// behavioural converter and scan reference.
module tb_clock_bcd_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] hours, minutes, seconds;
  logic       update;
  logic [5:0] conv_bin;
  logic [7:0] conv_bcd;
  logic       busy, done;
  logic [3:0] digit_bcd;
  logic [5:0] digit_sel;

  int errs = 0;
  int nchk = 0;
  int ndone = 0;
  logic [23:0] exp_disp = '0;
  int m_cnt, m_scan;

  always #5 clk = ~clk;

  assign conv_bcd = {4'(conv_bin / 10), 4'(conv_bin % 10)};

  clock_bcd_scan_ctrl #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .update(update),
    .conv_bin(conv_bin), .conv_bcd(conv_bcd),
    .busy(busy), .done(done),
    .digit_bcd(digit_bcd), .digit_sel(digit_sel)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_scan <= 0;
    end else if (m_cnt == 3) begin
      m_cnt  <= 0;
      m_scan <= (m_scan == 5) ? 0 : m_scan + 1;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_nib(input logic [23:0] d, input int i);
    logic [3:0] n;
    n = d[i*4 +: 4];
`ifdef BCD_SCAN_LZ_BLANK_EN
    if (i == 5 && n == 4'd0) n = 4'hF;
`endif
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (done) ndone++;
  endtask

  task automatic check_scan();
    chk("scan_sel", 32'(digit_sel), 32'(6'd1 << m_scan));
    chk("scan_dig", 32'(digit_bcd), 32'(exp_nib(exp_disp, m_scan)));
  endtask

  int cv[6] = '{56, 56, 34, 34, 12, 12};

  initial begin
    rst = 1'b1; update = 1'b0;
    hours = '0; minutes = '0; seconds = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_conv", 32'(conv_bin), 0);
    chk("rst_sel", 32'(digit_sel), 1);
    chk("rst_dig", 32'(digit_bcd), 0);
    rst = 1'b0;

    // 12:34:56 basic sequence
    hours = 12; minutes = 34; seconds = 56; update = 1'b1;
    step();
    update = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t1_conv", 32'(conv_bin), 32'(cv[i]));
      chk("t1_busy", 32'(busy), 1);
      chk("t1_done", 32'(done), 0);
      check_scan();
      step();
    end
    chk("t1_busy_commit", 32'(busy), 1);
    chk("t1_done_commit", 32'(done), 0);
    step();
    exp_disp = 24'h123456;
    chk("t1_done", 32'(done), 1);
    chk("t1_busy_end", 32'(busy), 0);
    check_scan();
    step();
    chk("t1_done_off", 32'(done), 0);
    repeat (26) begin
      step();
      check_scan();
    end

    // pending / overwrite
    ndone = 0;
    hours = 1; minutes = 2; seconds = 3; update = 1'b1;
    step();
    update = 1'b0;
    step(); step();
    hours = 9; minutes = 8; seconds = 7; update = 1'b1;
    step();
    update = 1'b0;
    chk("t2_busy_p3", 32'(busy), 1);
    step(); step(); step();
    hours = 63; minutes = 0; seconds = 5; update = 1'b1;
    step();
    update = 1'b0;
    exp_disp = 24'h010203;
    chk("t2_commit1", 32'(done), 1);
    chk("t2_busy_restart", 32'(busy), 1);
    chk("t2_conv_restart", 32'(conv_bin), 5);
    check_scan();
    repeat (6) begin
      step();
      chk("t2_busy", 32'(busy), 1);
      chk("t2_done_mid", 32'(done), 0);
      check_scan();
    end
    step();
    exp_disp = 24'h630005;
    chk("t2_commit2", 32'(done), 1);
    chk("t2_busy_end", 32'(busy), 0);
    check_scan();
    repeat (26) begin
      step();
      check_scan();
      chk("t2_idle", 32'(busy), 0);
    end
    chk("t2_ndone", 32'(ndone), 2);

    // reset in min CAPTURE
    hours = 12; minutes = 34; seconds = 56; update = 1'b1;
    step();
    update = 1'b0;
    step(); step(); step();
    chk("t3_conv_min", 32'(conv_bin), 34);
    chk("t3_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("t3_busy", 32'(busy), 0);
    chk("t3_done", 32'(done), 0);
    chk("t3_conv", 32'(conv_bin), 0);
    chk("t3_sel", 32'(digit_sel), 1);
    chk("t3_dig", 32'(digit_bcd), 0);
    step();
    rst = 1'b0;
    exp_disp = '0;
    ndone = 0;
    repeat (30) begin
      step();
      check_scan();
      chk("t3_idle", 32'(busy), 0);
    end
    chk("t3_ndone", 32'(ndone), 0);

    // hours 5: hours-tens zero
    hours = 5; minutes = 0; seconds = 0; update = 1'b1;
    step();
    update = 1'b0;
    repeat (6) step();
    step();
    exp_disp = 24'h050000;
    chk("t4_done", 32'(done), 1);
    repeat (30) begin
      step();
      check_scan();
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
